// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//
// Conditions the board's raw slide switches and push-button for the data
// memory's memory-mapped I/O read path. Both inputs are brought into the
// clock domain with 2-flop synchronizers and then debounced. A change is
// only accepted after the synchronized value has been stable for
// DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk             system clock; all state updates on the rising edge
//   rst             asynchronous, active-high reset
//   sw_raw[15:0]    raw switch pins (asynchronous)
//   btn_raw         raw button pin (asynchronous, active-high)
//   ack             one-cycle pulse from the CPU side that clears buttonOn
//   io_rdata_switch debounced switch vector
//   buttonOn        sticky press-pending flag
//   btn_level       debounced button level (1 in PRESSED / RELEASE_WAIT)
//   press_count     accepted presses, modulo 256
//
// Press/acknowledge protocol: buttonOn is set on every accepted press and
// stays set until the CPU pulses ack. A press accepted on the same edge as
// an ack wins, so a new press is never lost. Several presses before an ack
// collapse into one pending flag; press_count still counts each of them.

module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    input  logic        ack,
    output logic [15:0] io_rdata_switch,
    output logic        buttonOn,
    output logic        btn_level,
    output logic [7:0]  press_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------
    // Synchronizers. sw_prev holds the previous cycle's synchronized
    // switch vector so the debouncer can detect any bit changing.
    // ------------------------------------------------------------------
    logic [15:0] sw_meta;
    logic [15:0] sw_s;
    logic [15:0] sw_prev;
    logic        btn_meta;
    logic        btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= 16'h0000;
            sw_s     <= 16'h0000;
            sw_prev  <= 16'h0000;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            sw_meta  <= sw_raw;
            sw_s     <= sw_meta;
            sw_prev  <= sw_s;
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Switch debounce. The counter saturates at CNT_MAX; while saturated
    // and stable the output keeps reloading the same value, which is
    // harmless and avoids a separate "loaded" flag.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] sw_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt          <= '0;
            io_rdata_switch <= 16'h0000;
        end else if (sw_s != sw_prev) begin
            sw_cnt <= '0;
        end else if (sw_cnt == CNT_MAX) begin
            io_rdata_switch <= sw_s;
        end else begin
            sw_cnt <= sw_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce FSM
    // ------------------------------------------------------------------
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] btn_cnt;
    logic [CNT_W-1:0] btn_cnt_next;
    logic             press_accept;

    always_comb begin
        state_next   = state;
        btn_cnt_next = btn_cnt;
        press_accept = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next   = PRESS_WAIT;
                    btn_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (btn_cnt == CNT_MAX) begin
                    state_next   = PRESSED;
                    press_accept = 1'b1;
                end else begin
                    btn_cnt_next = btn_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next   = RELEASE_WAIT;
                    btn_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = PRESSED;
                end else if (btn_cnt == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    btn_cnt_next = btn_cnt + CNT_ONE;
                end
            end
        endcase
    end

    // btn_level is registered from the next state so it changes on the
    // same edge as the state transition rather than one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            btn_cnt     <= '0;
            btn_level   <= 1'b0;
            buttonOn    <= 1'b0;
            press_count <= 8'h00;
        end else begin
            state     <= state_next;
            btn_cnt   <= btn_cnt_next;
            btn_level <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            if (press_accept) begin
                press_count <= press_count + 8'd1;
                buttonOn    <= 1'b1;
            end else if (ack) begin
                buttonOn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner
//
// Bench for io_input_conditioner with DEBOUNCE_CYCLES=4. A behavioural
// model describes the design as "a synchronized input is accepted once its
// last DEBOUNCE_CYCLES+1 samples agree", tracked with run lengths. The
// model is compared with the DUT on every falling edge outside reset;
// directed scenarios add literal expectations on top.

module tb_io_input_conditioner;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_raw = 16'h0000;
    logic        btn_raw = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] io_rdata_switch;
    logic        buttonOn;
    logic        btn_level;
    logic [7:0]  press_count;

    int n_vec  = 0;
    int n_miss = 0;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .ack(ack),
        .io_rdata_switch(io_rdata_switch),
        .buttonOn(buttonOn),
        .btn_level(btn_level),
        .press_count(press_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_s1, m_s2;      // raw button seen one / two edges ago
    logic [15:0] m_w1, m_w2;      // raw switches seen one / two edges ago
    logic        m_bval;          // value of current button sample run
    int          m_brun;          // length of that run
    logic [15:0] m_sval;
    int          m_srun;
    logic        m_level;
    logic        m_pend;
    logic [7:0]  m_cnt;
    logic [15:0] m_sw;
    logic        bs;
    logic [15:0] sv;
    logic        press;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_w1 = 16'h0; m_w2 = 16'h0;
            m_bval = 1'b0; m_brun = 1;
            m_sval = 16'h0; m_srun = 1;
            m_level = 1'b0; m_pend = 1'b0; m_cnt = 8'h0; m_sw = 16'h0;
        end else begin
            bs = m_s2; sv = m_w2;
            m_s2 = m_s1; m_s1 = btn_raw;
            m_w2 = m_w1; m_w1 = sw_raw;

            if (bs == m_bval) begin
                if (m_brun < 1000) m_brun++;
            end else begin
                m_bval = bs; m_brun = 1;
            end
            if (sv == m_sval) begin
                if (m_srun < 1000) m_srun++;
            end else begin
                m_sval = sv; m_srun = 1;
            end

            if (m_srun >= D + 1) m_sw = sv;

            press = 1'b0;
            if (m_brun >= D + 1 && m_bval != m_level) begin
                m_level = m_bval;
                press   = m_bval;
            end
            if (press) begin
                m_pend = 1'b1;
                m_cnt  = m_cnt + 8'd1;
            end else if (ack) begin
                m_pend = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("model_switch", io_rdata_switch, m_sw);
            check("model_buttonOn", buttonOn, m_pend);
            check("model_btn_level", btn_level, m_level);
            check("model_press_count", press_count, m_cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        btn_raw = 1'b0; sw_raw = 16'h0; ack = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int b_left;
    int s_left;

    initial begin
        step(2);
        do_reset();

        // 1: reset state and first press timing
        check("rst_switch", io_rdata_switch, 16'h0);
        check("rst_buttonOn", buttonOn, 0);
        check("rst_level", btn_level, 0);
        check("rst_count", press_count, 0);
        btn_raw = 1'b1;
        step(6);
        check("s1_on_before_7", buttonOn, 0);
        check("s1_level_before_7", btn_level, 0);
        step(1);
        check("s1_on_edge7", buttonOn, 1);
        check("s1_level_edge7", btn_level, 1);
        check("s1_count_edge7", press_count, 1);

        // 2: bounce rejection
        do_reset();
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(1);
        btn_raw = 1'b1; step(6);
        check("s2_no_press_yet", buttonOn, 0);
        step(1);
        check("s2_on", buttonOn, 1);
        check("s2_count", press_count, 1);

        // 3: sticky flag, ack, release
        step(20);
        check("s3_on_held", buttonOn, 1);
        check("s3_count_held", press_count, 1);
        pulse_ack();
        check("s3_on_acked", buttonOn, 0);
        btn_raw = 1'b0;
        step(6);
        check("s3_level_before_rel", btn_level, 1);
        step(1);
        check("s3_level_released", btn_level, 0);

        // 4: ack colliding with the press edge
        do_reset();
        btn_raw = 1'b1;
        step(6);
        pulse_ack();
        check("s4_collision_on", buttonOn, 1);
        pulse_ack();
        check("s4_second_ack", buttonOn, 0);

        // 5: press counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            btn_raw = 1'b1; step(8);
            btn_raw = 1'b0; step(8);
        end
        check("s5_count_255", press_count, 8'd255);
        btn_raw = 1'b1; step(8);
        btn_raw = 1'b0; step(8);
        check("s5_count_wrap", press_count, 0);
        check("s5_on_pending", buttonOn, 1);
        pulse_ack();
        check("s5_on_acked", buttonOn, 0);

        // 6: switch debounce and asynchronous reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sw_raw = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            step(2);
        end
        check("s6_toggle_rejected", io_rdata_switch, 16'h0);
        sw_raw = 16'h00FF;
        step(6);
        check("s6_switch_before_7", io_rdata_switch, 16'h0);
        step(1);
        check("s6_switch_loaded", io_rdata_switch, 16'h00FF);
        btn_raw = 1'b1; step(7);
        check("s6_press_before_rst", press_count, 1);
        btn_raw = 1'b0; step(3);
        #1 rst = 1'b1;
        #1;
        check("s6_async_switch", io_rdata_switch, 16'h0);
        check("s6_async_on", buttonOn, 0);
        check("s6_async_level", btn_level, 0);
        check("s6_async_count", press_count, 0);
        #1 rst = 1'b0;
        sw_raw = 16'h0;
        @(negedge clk);
        btn_raw = 1'b1;
        step(7);
        check("s6_restart_count", press_count, 1);
        check("s6_restart_on", buttonOn, 1);

        // random phase: bouncy button, changing switches, random acks
        b_left = 0;
        s_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (b_left == 0) begin
                btn_raw = ~btn_raw;
                b_left  = $urandom_range(1, 12);
            end
            b_left--;
            if (s_left == 0) begin
                sw_raw = 16'($urandom);
                s_left = $urandom_range(1, 10);
            end
            s_left--;
            ack = ($urandom_range(0, 7) == 0);
            if (i == 1500) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end
        ack = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
